// File: rtl/physics_pkg.sv
// Shared types, default widths and saturation helper for the node integrator.
// Pure declarations: no logic, no latency, no flow control.
package physics_pkg;

    localparam int DEF_NUM_NODES     = 8;
    localparam int DEF_POSITION_SIZE = 16;
    localparam int DEF_VELOCITY_SIZE = 16;
    localparam int DEF_FORCE_SIZE    = 16;
    localparam int DEF_MASS_SHIFT    = 4;
    localparam int DEF_DT_SHIFT      = 4;
    localparam int DEF_GRAVITY       = -2;
    localparam int DEF_FLOOR_Y       = 0;

    // Working width for the un-saturated sums; must exceed every operand width by 2+ bits.
    localparam int CALC_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_COMMIT
    } integ_state_t;

    function automatic logic signed [CALC_W-1:0] sat_signed(
        input logic signed [CALC_W-1:0] v,
        input int                       w
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/node_update.sv
// Combinational semi-implicit Euler update of one node (velocity first, then position).
// Latency: zero cycles. Backpressure: none, pure function of its inputs.
// Optional floor clamp on y is built when NODE_FLOOR_CLAMP_EN is defined.
module node_update
    import physics_pkg::*;
#(
    parameter int POSITION_SIZE = DEF_POSITION_SIZE,
    parameter int VELOCITY_SIZE = DEF_VELOCITY_SIZE,
    parameter int FORCE_SIZE    = DEF_FORCE_SIZE,
    parameter int MASS_SHIFT    = DEF_MASS_SHIFT,
    parameter int DT_SHIFT      = DEF_DT_SHIFT,
    parameter int GRAVITY       = DEF_GRAVITY
`ifdef NODE_FLOOR_CLAMP_EN
    ,
    parameter int FLOOR_Y       = DEF_FLOOR_Y
`endif
) (
    input  logic signed [POSITION_SIZE-1:0] pos_x,
    input  logic signed [POSITION_SIZE-1:0] pos_y,
    input  logic signed [VELOCITY_SIZE-1:0] vel_x,
    input  logic signed [VELOCITY_SIZE-1:0] vel_y,
    input  logic signed [FORCE_SIZE-1:0]    force_x,
    input  logic signed [FORCE_SIZE-1:0]    force_y,
    output logic signed [POSITION_SIZE-1:0] next_x,
    output logic signed [POSITION_SIZE-1:0] next_y,
    output logic signed [VELOCITY_SIZE-1:0] next_vx,
    output logic signed [VELOCITY_SIZE-1:0] next_vy
);

    function automatic logic signed [CALC_W-1:0] sext_p(input logic signed [POSITION_SIZE-1:0] v);
        return {{(CALC_W-POSITION_SIZE){v[POSITION_SIZE-1]}}, v};
    endfunction

    function automatic logic signed [CALC_W-1:0] sext_v(input logic signed [VELOCITY_SIZE-1:0] v);
        return {{(CALC_W-VELOCITY_SIZE){v[VELOCITY_SIZE-1]}}, v};
    endfunction

    function automatic logic signed [CALC_W-1:0] sext_f(input logic signed [FORCE_SIZE-1:0] v);
        return {{(CALC_W-FORCE_SIZE){v[FORCE_SIZE-1]}}, v};
    endfunction

    function automatic logic signed [POSITION_SIZE-1:0] sat_p(input logic signed [CALC_W-1:0] v);
        logic signed [CALC_W-1:0] c;
        c = sat_signed(v, POSITION_SIZE);
        return c[POSITION_SIZE-1:0];
    endfunction

    function automatic logic signed [VELOCITY_SIZE-1:0] sat_v(input logic signed [CALC_W-1:0] v);
        logic signed [CALC_W-1:0] c;
        c = sat_signed(v, VELOCITY_SIZE);
        return c[VELOCITY_SIZE-1:0];
    endfunction

    always_comb begin
        next_vx = sat_v(sext_v(vel_x) + (sext_f(force_x) >>> MASS_SHIFT));
        next_vy = sat_v(sext_v(vel_y) + (sext_f(force_y) >>> MASS_SHIFT) + GRAVITY);
        // Position uses the freshly saturated velocity (semi-implicit step).
        next_x  = sat_p(sext_p(pos_x) + (sext_v(next_vx) >>> DT_SHIFT));
        next_y  = sat_p(sext_p(pos_y) + (sext_v(next_vy) >>> DT_SHIFT));
`ifdef NODE_FLOOR_CLAMP_EN
        if (next_y < POSITION_SIZE'(FLOOR_Y)) begin
            next_y = POSITION_SIZE'(FLOOR_Y);
            if (next_vy[VELOCITY_SIZE-1]) next_vy = '0;
        end
`endif
    end

endmodule

// File: rtl/node_integrator.sv
// Per-frame Euler integrator: beats update a shadow buffer, force_done commits it atomically.
// Latency: beat lands in shadow at its sampling edge; commit + step_done one cycle after done.
// Backpressure: none; one beat per cycle accepted, excess beats dropped and flagged.
// NODE_FLOOR_CLAMP_EN enables the floor clamp (and the FLOOR_Y parameter).
module node_integrator
    import physics_pkg::*;
#(
    parameter int NUM_NODES     = DEF_NUM_NODES,
    parameter int POSITION_SIZE = DEF_POSITION_SIZE,
    parameter int VELOCITY_SIZE = DEF_VELOCITY_SIZE,
    parameter int FORCE_SIZE    = DEF_FORCE_SIZE,
    parameter int MASS_SHIFT    = DEF_MASS_SHIFT,
    parameter int DT_SHIFT      = DEF_DT_SHIFT,
    parameter int GRAVITY       = DEF_GRAVITY
`ifdef NODE_FLOOR_CLAMP_EN
    ,
    parameter int FLOOR_Y       = DEF_FLOOR_Y
`endif
) (
    input  logic                                             clk_in,
    input  logic                                             rst_in,
    input  logic                                             force_valid,
    input  logic signed [FORCE_SIZE-1:0]                     force_x,
    input  logic signed [FORCE_SIZE-1:0]                     force_y,
    input  logic                                             force_done,
    input  logic                                             init_valid,
    input  logic [$clog2(NUM_NODES)-1:0]                     init_index,
    input  logic signed [POSITION_SIZE-1:0]                  init_x,
    input  logic signed [POSITION_SIZE-1:0]                  init_y,
    input  logic signed [VELOCITY_SIZE-1:0]                  init_vx,
    input  logic signed [VELOCITY_SIZE-1:0]                  init_vy,
    output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]     nodes,
    output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]     velocities,
    output logic                                             step_done,
    output logic                                             busy,
    output logic                                             overflow_flag,
    output logic                                             short_flag
);

    localparam int IW = $clog2(NUM_NODES);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] N_CNT = CW'(NUM_NODES);

    integ_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_after;
    logic [IW-1:0] beat_idx;
    logic          beat_live, beat_ok, beat_drop, short_set;

    logic signed [POSITION_SIZE-1:0] sh_x  [NUM_NODES];
    logic signed [POSITION_SIZE-1:0] sh_y  [NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] sh_vx [NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] sh_vy [NUM_NODES];
    logic signed [POSITION_SIZE-1:0] cm_x  [NUM_NODES];
    logic signed [POSITION_SIZE-1:0] cm_y  [NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] cm_vx [NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] cm_vy [NUM_NODES];

    logic signed [POSITION_SIZE-1:0] upd_x, upd_y;
    logic signed [VELOCITY_SIZE-1:0] upd_vx, upd_vy;

    // Beats arriving while the commit is in flight are not part of any frame.
    assign beat_live = force_valid && (state_q != ST_COMMIT);
    assign beat_ok   = beat_live && (cnt_q < N_CNT);
    assign beat_drop = beat_live && (cnt_q >= N_CNT);
    assign cnt_after = cnt_q + CW'(beat_ok);
    assign beat_idx  = cnt_q[IW-1:0];
    assign short_set = force_done && (state_q != ST_COMMIT) && (cnt_after < N_CNT);
    assign busy      = (state_q == ST_ACCUM) || (state_q == ST_COMMIT);

    node_update #(
        .POSITION_SIZE (POSITION_SIZE),
        .VELOCITY_SIZE (VELOCITY_SIZE),
        .FORCE_SIZE    (FORCE_SIZE),
        .MASS_SHIFT    (MASS_SHIFT),
        .DT_SHIFT      (DT_SHIFT),
        .GRAVITY       (GRAVITY)
`ifdef NODE_FLOOR_CLAMP_EN
        ,
        .FLOOR_Y       (FLOOR_Y)
`endif
    ) u_node_update (
        .pos_x   (sh_x[beat_idx]),
        .pos_y   (sh_y[beat_idx]),
        .vel_x   (sh_vx[beat_idx]),
        .vel_y   (sh_vy[beat_idx]),
        .force_x (force_x),
        .force_y (force_y),
        .next_x  (upd_x),
        .next_y  (upd_y),
        .next_vx (upd_vx),
        .next_vy (upd_vy)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (force_done)       state_d = ST_COMMIT;
                else if (force_valid) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (force_done) state_d = ST_COMMIT;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            step_done     <= 1'b0;
            overflow_flag <= 1'b0;
            short_flag    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= (state_q == ST_COMMIT) ? '0 : cnt_after;
            step_done     <= (state_q == ST_COMMIT);
            overflow_flag <= overflow_flag | beat_drop;
            short_flag    <= short_flag | short_set;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                sh_x[i]  <= '0;
                sh_y[i]  <= '0;
                sh_vx[i] <= '0;
                sh_vy[i] <= '0;
                cm_x[i]  <= '0;
                cm_y[i]  <= '0;
                cm_vx[i] <= '0;
                cm_vy[i] <= '0;
            end
        end else begin
            if ((state_q == ST_IDLE) && init_valid) begin
                sh_x[init_index]  <= init_x;
                sh_y[init_index]  <= init_y;
                sh_vx[init_index] <= init_vx;
                sh_vy[init_index] <= init_vy;
                cm_x[init_index]  <= init_x;
                cm_y[init_index]  <= init_y;
                cm_vx[init_index] <= init_vx;
                cm_vy[init_index] <= init_vy;
            end
            // A beat on the same node as a concurrent init wins in the shadow.
            if (beat_ok) begin
                sh_x[beat_idx]  <= upd_x;
                sh_y[beat_idx]  <= upd_y;
                sh_vx[beat_idx] <= upd_vx;
                sh_vy[beat_idx] <= upd_vy;
            end
            if (state_q == ST_COMMIT) begin
                for (int i = 0; i < NUM_NODES; i++) begin
                    cm_x[i]  <= sh_x[i];
                    cm_y[i]  <= sh_y[i];
                    cm_vx[i] <= sh_vx[i];
                    cm_vy[i] <= sh_vy[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_NODES; i++) begin
            nodes[0][i]      = cm_x[i];
            nodes[1][i]      = cm_y[i];
            velocities[0][i] = cm_vx[i];
            velocities[1][i] = cm_vy[i];
        end
    end

endmodule

// File: tb/tb_node_integrator.sv
// Directed and randomized frames against an arithmetic reference of the Euler step.
module tb_node_integrator;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              force_valid, force_done, init_valid;
    logic [15:0]       force_x, force_y;
    logic [2:0]        init_index;
    logic [15:0]       init_x, init_y, init_vx, init_vy;
    logic [1:0][7:0][15:0] nodes, velocities;
    logic              step_done, busy, overflow_flag, short_flag;

    int n_pass  = 0;
    int n_total = 0;
    int cpos[2][8];
    int cvel[2][8];
    int spos[2][8];
    int svel[2][8];
    bit m_ovf, m_short;
    int fxq[16];
    int fyq[16];

    node_integrator dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .force_valid   (force_valid),
        .force_x       (force_x),
        .force_y       (force_y),
        .force_done    (force_done),
        .init_valid    (init_valid),
        .init_index    (init_index),
        .init_x        (init_x),
        .init_y        (init_y),
        .init_vx       (init_vx),
        .init_vy       (init_vy),
        .nodes         (nodes),
        .velocities    (velocities),
        .step_done     (step_done),
        .busy          (busy),
        .overflow_flag (overflow_flag),
        .short_flag    (short_flag)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // Floor division by 2^s, done with plain integer arithmetic.
    function automatic int fshift(input int a, input int s);
        int d;
        int q;
        d = 1 << s;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int satw(input int a, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (a > hi) return hi;
        if (a < lo) return lo;
        return a;
    endfunction

    task automatic model_beat(input int k, input int fx, input int fy);
        int x, y, vx, vy;
        if (k >= 8) begin
            m_ovf = 1'b1;
            return;
        end
        x  = spos[0][k];
        y  = spos[1][k];
        vx = satw(svel[0][k] + fshift(fx, 4), 16);
        vy = satw(svel[1][k] + fshift(fy, 4) - 2, 16);
        x  = satw(x + fshift(vx, 4), 16);
        y  = satw(y + fshift(vy, 4), 16);
`ifdef NODE_FLOOR_CLAMP_EN
        if (y < 0) begin
            y = 0;
            if (vy < 0) vy = 0;
        end
`endif
        spos[0][k] = x;
        spos[1][k] = y;
        svel[0][k] = vx;
        svel[1][k] = vy;
    endtask

    task automatic model_reset();
        for (int a = 0; a < 2; a++)
            for (int i = 0; i < 8; i++) begin
                cpos[a][i] = 0;
                cvel[a][i] = 0;
                spos[a][i] = 0;
                svel[a][i] = 0;
            end
        m_ovf   = 1'b0;
        m_short = 1'b0;
    endtask

    task automatic check_state(input string tag);
        logic [1:0][7:0][15:0] en;
        logic [1:0][7:0][15:0] ev;
        for (int a = 0; a < 2; a++)
            for (int i = 0; i < 8; i++) begin
                en[a][i] = 16'(cpos[a][i]);
                ev[a][i] = 16'(cvel[a][i]);
            end
        chk({tag, "_pos"}, nodes, en);
        chk({tag, "_vel"}, velocities, ev);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic init_node(input int i, input int x, input int y, input int vx, input int vy);
        init_valid = 1'b1;
        init_index = 3'(i);
        init_x     = 16'(x);
        init_y     = 16'(y);
        init_vx    = 16'(vx);
        init_vy    = 16'(vy);
        step();
        init_valid = 1'b0;
        spos[0][i] = x;  cpos[0][i] = x;
        spos[1][i] = y;  cpos[1][i] = y;
        svel[0][i] = vx; cvel[0][i] = vx;
        svel[1][i] = vy; cvel[1][i] = vy;
        check_state("init");
    endtask

    task automatic run_frame(input int n, input bit done_last, input bit noise);
        for (int k = 0; k < n; k++) begin
            force_valid = 1'b1;
            force_x     = 16'(fxq[k]);
            force_y     = 16'(fyq[k]);
            force_done  = done_last && (k == n - 1);
            init_valid  = noise && (k >= 1);
            init_index  = 3'($urandom);
            init_x      = 16'($urandom);
            init_y      = 16'($urandom);
            init_vx     = 16'($urandom);
            init_vy     = 16'($urandom);
            step();
            model_beat(k, fxq[k], fyq[k]);
            chk("mid_busy", busy, 1);
            check_state("mid_stable");
        end
        force_valid = 1'b0;
        init_valid  = 1'b0;
        force_done  = 1'b0;
        if (!(done_last && n > 0)) begin
            force_done = 1'b1;
            step();
            force_done = 1'b0;
        end
        if (n < 8) m_short = 1'b1;
        chk("commit_step_done_low", step_done, 0);
        chk("commit_busy", busy, 1);
        check_state("pre_commit");
        step();
        for (int a = 0; a < 2; a++)
            for (int i = 0; i < 8; i++) begin
                cpos[a][i] = spos[a][i];
                cvel[a][i] = svel[a][i];
            end
        chk("step_done_high", step_done, 1);
        chk("idle_busy", busy, 0);
        check_state("post_commit");
        chk("overflow_flag", overflow_flag, m_ovf);
        chk("short_flag", short_flag, m_short);
        step();
        chk("step_done_pulse", step_done, 0);
    endtask

    task automatic clear_forces();
        for (int k = 0; k < 16; k++) begin
            fxq[k] = 0;
            fyq[k] = 0;
        end
    endtask

    initial begin
        rst_in      = 1'b0;
        force_valid = 1'b0;
        force_done  = 1'b0;
        init_valid  = 1'b0;
        force_x     = '0;
        force_y     = '0;
        init_index  = '0;
        init_x      = '0;
        init_y      = '0;
        init_vx     = '0;
        init_vy     = '0;
        model_reset();
        clear_forces();
        #12;
        check_state("reset");
        chk("reset_step_done", step_done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", overflow_flag, 0);
        chk("reset_short", short_flag, 0);
        rst_in = 1'b1;
        step();

        init_node(0, 100, 200, 0, 0);
        run_frame(8, 1'b1, 1'b0);
        chk("t1_x", nodes[0][0], 16'd100);
        chk("t1_y", nodes[1][0], 16'd199);
        chk("t1_vy", velocities[1][0], 16'hFFFE);

        init_node(3, 0, 0, 32, 0);
        clear_forces();
        fxq[3] = 160;
        run_frame(8, 1'b1, 1'b0);
        chk("t2_vx", velocities[0][3], 16'd42);
        chk("t2_x", nodes[0][3], 16'd2);

        init_node(1, 0, 0, 32767, 0);
        init_node(2, 0, 0, -32768, 0);
        clear_forces();
        fxq[1] = 16000;
        fxq[2] = -16000;
        run_frame(8, 1'b0, 1'b0);
        chk("t3_sat_hi", velocities[0][1], 16'h7FFF);
        chk("t3_sat_lo", velocities[0][2], 16'h8000);

        clear_forces();
        run_frame(10, 1'b1, 1'b1);
        chk("t4_ovf", overflow_flag, 1);
        run_frame(5, 1'b1, 1'b0);
        chk("t4_short", short_flag, 1);

        init_node(4, 0, 0, 0, -20);
        run_frame(8, 1'b1, 1'b0);
`ifdef NODE_FLOOR_CLAMP_EN
        chk("t5_clamp_y", nodes[1][4], 16'd0);
        chk("t5_clamp_vy", velocities[1][4], 16'd0);
`else
        chk("t5_free_y", nodes[1][4], 16'hFFFE);
        chk("t5_free_vy", velocities[1][4], 16'hFFEA);
`endif

        for (int k = 0; k < 3; k++) begin
            force_valid = 1'b1;
            force_x     = 16'($urandom);
            force_y     = 16'($urandom);
            step();
        end
        force_valid = 1'b0;
        #2;
        rst_in = 1'b0;
        #1;
        model_reset();
        check_state("async_reset");
        chk("async_reset_busy", busy, 0);
        chk("async_reset_ovf", overflow_flag, 0);
        chk("async_reset_short", short_flag, 0);
        chk("async_reset_step_done", step_done, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        step();

        for (int j = 0; j < 8; j++)
            init_node(j, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 16; k++) begin
                fxq[k] = int'($urandom_range(0, 65535)) - 32768;
                fyq[k] = int'($urandom_range(0, 65535)) - 32768;
            end
            run_frame(int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
